// File: rtl/lfsr_pkg.sv
// Shared types for the LFSR pattern generator: feedback mode and control state.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lfsr_state_e;

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state function of a WIDTH-bit LFSR in Fibonacci or Galois form.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] lfsr_i,
  input  logic [WIDTH-1:0] taps_i,
  input  lfsr_mode_e       mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             is_zero_o
);

  // Fibonacci shifts the tap parity in at bit 0; Galois shifts right and folds taps on a carried-out 1.
  always_comb begin
    next_o = lfsr_i;
    case (mode_i)
      LFSR_FIB: next_o = {lfsr_i[WIDTH-2:0], ^(lfsr_i & taps_i)};
      LFSR_GAL: begin
        if (lfsr_i[0]) begin
          next_o = (lfsr_i >> 1'b1) ^ taps_i;
        end else begin
          next_o = lfsr_i >> 1'b1;
        end
      end
      default:  next_o = lfsr_i;
    endcase
    is_zero_o = (next_o == '0);
  end

endmodule

// File: rtl/lfsr_pattern_gen.sv
// Programmable LFSR test-pattern source with burst counting and a valid/ready output stream.
module lfsr_pattern_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01,
  parameter int               CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [WIDTH-1:0] cfg_taps,
  input  logic             cfg_mode,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic             start,
  input  logic             stop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] LFSR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  lfsr_state_e      state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  lfsr_mode_e       mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             stop_pend_q, stop_pend_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] next_s;
  logic             next_zero_s;
  logic             hs_s;
  logic             last_s;

  lfsr_next #(.WIDTH(WIDTH)) u_next (
    .lfsr_i    (lfsr_q),
    .taps_i    (taps_q),
    .mode_i    (mode_q),
    .next_o    (next_s),
    .is_zero_o (next_zero_s)
  );

  assign hs_s   = out_valid_q & out_ready;
  assign last_s = (num_q != '0) && (count_q == (num_q - CNT_ONE));

  // Control: burst start, handshake-driven advance, count end and stop handling.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    seed_d      = seed_q;
    taps_d      = taps_q;
    mode_d      = mode_q;
    count_d     = count_q;
    num_d       = num_q;
    stop_pend_d = stop_pend_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    lockup_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // New configuration is visible to a start in the same cycle.
        if (cfg_load) begin
          seed_d = (cfg_seed == '0) ? LFSR_ONE : cfg_seed;
          taps_d = cfg_taps;
          mode_d = lfsr_mode_e'(cfg_mode);
        end else begin
          seed_d = seed_q;
        end
        if (start) begin
          state_d     = ST_RUN;
          lfsr_d      = seed_d;
          count_d     = '0;
          num_d       = num_patterns;
          stop_pend_d = 1'b0;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hs_s) begin
          lfsr_d   = next_zero_s ? seed_q : next_s;
          lockup_d = next_zero_s;
          count_d  = count_q + CNT_ONE;
          if (last_s) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else if (stop || stop_pend_q) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            stop_pend_d = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= DEFAULT_SEED;
      seed_q      <= DEFAULT_SEED;
      taps_q      <= DEFAULT_TAPS;
      mode_q      <= LFSR_FIB;
      count_q     <= '0;
      num_q       <= '0;
      stop_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      seed_q      <= seed_d;
      taps_q      <= taps_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      num_q       <= num_d;
      stop_pend_q <= stop_pend_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lockup_q    <= lockup_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = lfsr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Self-checking bench: directed literal sequences plus randomized traffic against a behavioural model.
module tb_lfsr_pattern_gen;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_load;
  logic [W-1:0]  cfg_seed;
  logic [W-1:0]  cfg_taps;
  logic          cfg_mode;
  logic [CW-1:0] num_patterns;
  logic          start;
  logic          stop;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          done;
  logic          lockup;

  int vectors    = 0;
  int miscompares = 0;
  bit checks_on  = 1'b0;

  // Reference model state.
  logic          m_valid;
  logic [W-1:0]  m_lfsr;
  logic [W-1:0]  m_seed;
  logic [W-1:0]  m_taps;
  logic          m_mode;
  logic [CW-1:0] m_cnt;
  logic [CW-1:0] m_num;
  logic          m_pend;
  logic          m_done;
  logic          m_lock;

  logic [W-1:0] fib_exp [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  logic [W-1:0] gal_exp [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

  always #5 clk = ~clk;

  lfsr_pattern_gen #(
    .WIDTH        (W),
    .DEFAULT_TAPS (8'hB8),
    .DEFAULT_SEED (8'h01),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_load     (cfg_load),
    .cfg_seed     (cfg_seed),
    .cfg_taps     (cfg_taps),
    .cfg_mode     (cfg_mode),
    .num_patterns (num_patterns),
    .start        (start),
    .stop         (stop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done),
    .lockup       (lockup)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next pattern from the polynomial rules, using plain arithmetic.
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] l, input logic [W-1:0] t,
                                            input logic m);
    int v;
    int ones;
    v = int'(l);
    if (!m) begin
      ones = $countones(l & t);
      v = (v * 2) % 256 + (ones % 2);
    end else begin
      if (v % 2 == 1) v = (v / 2) ^ int'(t);
      else            v = v / 2;
    end
    return W'(v);
  endfunction

  // Advance one clock: model consumes the inputs seen at this edge, then wait for the falling edge.
  task automatic tick();
    logic [W-1:0] nxt;
    logic         hs;
    logic         last;
    @(posedge clk);
    hs     = m_valid && out_ready;
    m_done = 1'b0;
    m_lock = 1'b0;
    if (rst) begin
      m_valid = 1'b0; m_lfsr = 8'h01; m_seed = 8'h01; m_taps = 8'hB8; m_mode = 1'b0;
      m_cnt = 16'd0; m_num = 16'd0; m_pend = 1'b0;
    end else if (!m_valid) begin
      if (cfg_load) begin
        m_seed = (cfg_seed == 8'h00) ? 8'h01 : cfg_seed;
        m_taps = cfg_taps;
        m_mode = cfg_mode;
      end
      if (start) begin
        m_lfsr = m_seed; m_cnt = 16'd0; m_num = num_patterns; m_pend = 1'b0; m_valid = 1'b1;
      end
    end else if (hs) begin
      nxt = ref_next(m_lfsr, m_taps, m_mode);
      if (nxt == 8'h00) begin
        nxt    = m_seed;
        m_lock = 1'b1;
      end
      m_lfsr = nxt;
      last   = (m_num != 16'd0) && (m_cnt == 16'(m_num - 16'd1));
      m_cnt  = 16'(m_cnt + 16'd1);
      if (last) begin
        m_valid = 1'b0; m_done = 1'b1; m_pend = 1'b0;
      end else if (stop || m_pend) begin
        m_valid = 1'b0; m_pend = 1'b0;
      end
    end else if (stop) begin
      m_pend = 1'b1;
    end
    @(negedge clk);
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (checks_on) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("busy",      32'(busy),      32'(m_valid));
      chk("done",      32'(done),      32'(m_done));
      chk("lockup",    32'(lockup),    32'(m_lock));
      chk("out_data",  32'(out_data),  32'(m_lfsr));
    end
  end

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_seed = 8'h00; cfg_taps = 8'h00; cfg_mode = 1'b0;
    num_patterns = 16'd0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    checks_on = 1'b1;
    rst = 1'b0;
    chk("reset_data",  32'(out_data),  32'h01);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_busy",  32'(busy),      32'h0);

    // Fibonacci burst of 4 with default configuration.
    num_patterns = 16'd4; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fib_seq", 32'(out_data), 32'(fib_exp[i]));
      tick();
    end
    chk("fib_done", 32'(done), 32'h1);
    chk("fib_busy", 32'(busy), 32'h0);
    tick();
    chk("fib_done_pulse", 32'(done), 32'h0);

    // Galois burst of 6, configured in the same cycle as start.
    cfg_load = 1'b1; cfg_seed = 8'h01; cfg_taps = 8'hB8; cfg_mode = 1'b1;
    num_patterns = 16'd6; start = 1'b1;
    tick();
    cfg_load = 1'b0; start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("gal_seq", 32'(out_data), 32'(gal_exp[i]));
      tick();
    end
    chk("gal_done", 32'(done), 32'h1);

    // Backpressure in the middle of a 10-pattern Fibonacci burst.
    cfg_load = 1'b1; cfg_mode = 1'b0; num_patterns = 16'd10; start = 1'b1;
    tick();
    cfg_load = 1'b0; start = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data",  32'(out_data),  32'h08);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    repeat (7) tick();
    chk("bp_done", 32'(done), 32'h1);

    // Free-run over the full maximal-length period, then stop.
    num_patterns = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (255) tick();
    chk("free_wrap_data",  32'(out_data),  32'h01);
    chk("free_wrap_valid", 32'(out_valid), 32'h1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid", 32'(out_valid), 32'h0);
    chk("stop_done",  32'(done),      32'h0);

    // Zero seed and empty tap mask: shifting out the single 1 forces lockup recovery.
    cfg_load = 1'b1; cfg_seed = 8'h00; cfg_taps = 8'h00; start = 1'b1;
    tick();
    cfg_load = 1'b0; start = 1'b0;
    chk("zero_seed", 32'(out_data), 32'h01);
    repeat (8) tick();
    chk("lockup_data",  32'(out_data), 32'h01);
    chk("lockup_pulse", 32'(lockup),   32'h1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // cfg_load during RUN is ignored; reset mid-burst under backpressure.
    cfg_load = 1'b1; cfg_seed = 8'h3C; cfg_taps = 8'hB8; start = 1'b1;
    tick();
    start = 1'b0; cfg_seed = 8'h55; out_ready = 1'b0;
    tick();
    cfg_load = 1'b0;
    chk("run_cfg_ignored", 32'(out_data), 32'h3C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    chk("rst_data",  32'(out_data),  32'h01);
    out_ready = 1'b1; num_patterns = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_seed_default", 32'(out_data), 32'h01);
    repeat (3) tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cfg_load  = ($urandom_range(0, 7) == 0);
      cfg_seed  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      cfg_taps  = ($urandom_range(0, 4) == 0) ? 8'h40 : 8'($urandom_range(0, 255));
      cfg_mode  = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      num_patterns = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      tick();
    end

    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_load = 1'b0;
    tick();
    checks_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
